// File: rtl/acc_unit.sv
`timescale 1ns/1ps
`default_nettype none
// acc_unit: ACC/MR/flag register stage with ALU writeback latency tracking and a valid/ready store port.
// Optional ACC_SAT_EN: saturate ACC on overflowing ALU writeback.  Rev 1.0
module acc_unit #(
  parameter int              DW      = 16,
  parameter int              ALU_LAT = 1,
  parameter logic [DW-1:0]   ACC_RST = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd,
  output logic          cmd_ready,
  input  logic [DW-1:0] br_data,
  input  logic [DW-1:0] alu2acc,
  input  logic [DW-1:0] mr_data,
  input  logic [3:0]    alu_flags,
  output logic [DW-1:0] acc2alu,
  output logic          acc_alu_io_rw,
  output logic [DW-1:0] mr_q,
  output logic [3:0]    flags,
  output logic          mem_wr_valid,
  input  logic          mem_wr_ready,
  output logic [DW-1:0] mem_wr_data
);

  localparam logic [2:0] CMD_LOAD_BR = 3'd1;
  localparam logic [2:0] CMD_ALU_WB  = 3'd2;
  localparam logic [2:0] CMD_STORE   = 3'd3;
  localparam logic [2:0] CMD_MR2ACC  = 3'd4;
  localparam logic [3:0] LAT_M1      = 4'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALU_WAIT = 2'd1,
    STORE    = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            take;
  logic            capture;
  logic [3:0]      cnt;
  logic            pre_sign;
  logic [DW-1:0]   acc;
  logic [DW-1:0]   wb_val;
  logic [3:0]      wb_flags;

  assign acc2alu = acc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    take          = 1'b0;
    capture       = 1'b0;
    cmd_ready     = (state == IDLE);
    acc_alu_io_rw = (state == ALU_WAIT);
    mem_wr_valid  = (state == STORE);
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          take = 1'b1;
          case (cmd)
            CMD_ALU_WB: state_nxt = ALU_WAIT;
            CMD_STORE:  state_nxt = STORE;
            default:    state_nxt = IDLE;
          endcase
        end
      end
      ALU_WAIT: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      STORE: begin
        if (mem_wr_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Saturation direction follows the ACC sign sampled when the ALU op was issued.
  always_comb begin
    wb_val   = alu2acc;
    wb_flags = alu_flags;
`ifdef ACC_SAT_EN
    if (alu_flags[2]) begin
      wb_val   = pre_sign ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      wb_flags = {alu_flags[3], 1'b1, (wb_val == '0), wb_val[DW-1]};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= ACC_RST;
      mr_q        <= '0;
      flags       <= 4'b0010;
      cnt         <= 4'd0;
      pre_sign    <= 1'b0;
      mem_wr_data <= '0;
    end else begin
      if (take) begin
        case (cmd)
          CMD_LOAD_BR: begin
            acc   <= br_data;
            flags <= {2'b00, (br_data == '0), br_data[DW-1]};
          end
          CMD_ALU_WB: begin
            pre_sign <= acc[DW-1];
            cnt      <= LAT_M1;
          end
          CMD_STORE:   mem_wr_data <= acc;
          CMD_MR2ACC: begin
            acc   <= mr_q;
            flags <= {2'b00, (mr_q == '0), mr_q[DW-1]};
          end
          default: ;
        endcase
      end
      if (state == ALU_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (capture) begin
        acc   <= wb_val;
        flags <= wb_flags;
        if (alu_flags[3]) mr_q <= mr_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_unit.sv
`timescale 1ns/1ps
`default_nettype none
// tb_acc_unit: directed and randomized checks of acc_unit against a transaction-level model.
module tb_acc_unit;

  localparam int DW  = 16;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic          cmd_ready;
  logic [DW-1:0] br_data;
  logic [DW-1:0] alu2acc;
  logic [DW-1:0] mr_data;
  logic [3:0]    alu_flags;
  logic [DW-1:0] acc2alu;
  logic          acc_alu_io_rw;
  logic [DW-1:0] mr_q;
  logic [3:0]    flags;
  logic          mem_wr_valid;
  logic          mem_wr_ready;
  logic [DW-1:0] mem_wr_data;

  always #5 clk = ~clk;

  acc_unit #(.DW(DW), .ALU_LAT(LAT), .ACC_RST('0)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .br_data(br_data), .alu2acc(alu2acc), .mr_data(mr_data), .alu_flags(alu_flags),
    .acc2alu(acc2alu), .acc_alu_io_rw(acc_alu_io_rw), .mr_q(mr_q), .flags(flags),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_data(mem_wr_data)
  );

  int errors = 0;
  int checks = 0;

  // Transaction-level model state
  logic [15:0] m_acc = '0;
  logic [15:0] m_mr = '0;
  logic [15:0] m_sdata = '0;
  logic [3:0]  m_flags = 4'b0010;
  int          m_wait = 0;
  bit          m_storing = 1'b0;
  logic        m_sign = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [15:0] v;
    logic [3:0]  f;
    if (rst) begin
      m_acc = '0; m_mr = '0; m_flags = 4'b0010; m_wait = 0; m_storing = 1'b0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        v = alu2acc;
        f = alu_flags;
`ifdef ACC_SAT_EN
        if (alu_flags[2]) begin
          v = m_sign ? 16'h8000 : 16'h7FFF;
          f = {alu_flags[3], 1'b1, (v == 16'h0), v[15]};
        end
`endif
        m_acc   = v;
        m_flags = f;
        if (alu_flags[3]) m_mr = mr_data;
      end
    end else if (m_storing) begin
      if (mem_wr_ready) m_storing = 1'b0;
    end else if (cmd_valid) begin
      case (cmd)
        3'd1: begin m_acc = br_data; m_flags = {2'b00, (br_data == 16'h0), br_data[15]}; end
        3'd2: begin m_sign = m_acc[15]; m_wait = LAT; end
        3'd3: begin m_storing = 1'b1; m_sdata = m_acc; end
        3'd4: begin m_acc = m_mr; m_flags = {2'b00, (m_mr == 16'h0), m_mr[15]}; end
        default: ;
      endcase
    end
  endtask

  // One clock: advance the model on the edge, compare every output mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("cmd_ready", 32'(cmd_ready), 32'(m_wait == 0 && !m_storing));
    chk("acc_alu_io_rw", 32'(acc_alu_io_rw), 32'(m_wait > 0));
    chk("mem_wr_valid", 32'(mem_wr_valid), 32'(m_storing));
    chk("acc2alu", 32'(acc2alu), 32'(m_acc));
    chk("mr_q", 32'(mr_q), 32'(m_mr));
    chk("flags", 32'(flags), 32'(m_flags));
    if (m_storing) chk("mem_wr_data", 32'(mem_wr_data), 32'(m_sdata));
  endtask

  task automatic cmd_go(input logic [2:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick();
    cmd_valid = 1'b0;
    cmd       = 3'd0;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int vcnt;
    rst = 1'b1; cmd_valid = 1'b0; cmd = 3'd0; br_data = '0; alu2acc = '0;
    mr_data = '0; alu_flags = 4'd0; mem_wr_ready = 1'b0;

    // Reset held two cycles
    tick(); tick();
    rst = 1'b0;
    chk("rst_acc", 32'(acc2alu), 32'h0);
    chk("rst_mr", 32'(mr_q), 32'h0);
    chk("rst_flags", 32'(flags), 32'h2);
    chk("rst_ready", 32'(cmd_ready), 32'h1);
    chk("rst_valid", 32'(mem_wr_valid), 32'h0);

    // LOAD_BR of a negative value
    br_data = 16'h8001;
    cmd_go(3'd1);
    chk("load_acc", 32'(acc2alu), 32'h8001);
    chk("load_flags", 32'(flags), 32'h1);
    chk("load_ready", 32'(cmd_ready), 32'h1);

    // ALU writeback, single-cycle latency
    alu2acc = 16'h1234; alu_flags = 4'b0000;
    cmd_go(3'd2);
    chk("wb_busy_ready", 32'(cmd_ready), 32'h0);
    chk("wb_busy_rw", 32'(acc_alu_io_rw), 32'h1);
    tick();
    chk("wb_acc", 32'(acc2alu), 32'h1234);
    chk("wb_ready", 32'(cmd_ready), 32'h1);
    chk("wb_rw", 32'(acc_alu_io_rw), 32'h0);

    // Multiply writeback into MR, then MR->ACC
    alu2acc = 16'h0000; mr_data = 16'h0003; alu_flags = 4'b1000;
    cmd_go(3'd2);
    tick();
    chk("mr_val", 32'(mr_q), 32'h3);
    chk("mr_flag", 32'(flags[3]), 32'h1);
    cmd_go(3'd4);
    chk("mr2acc_acc", 32'(acc2alu), 32'h3);
    chk("mr2acc_flags", 32'(flags), 32'h0);

    // Store with ready held low three cycles; a command arrives on the completion cycle
    br_data = 16'h1234;
    cmd_go(3'd1);
    mem_wr_ready = 1'b0;
    cmd_go(3'd3);
    vcnt = 0;
    if (mem_wr_valid) vcnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_wr_valid) vcnt++;
      chk("store_data", 32'(mem_wr_data), 32'h1234);
    end
    mem_wr_ready = 1'b1; cmd_valid = 1'b1; cmd = 3'd1; br_data = 16'h5555;
    tick();
    mem_wr_ready = 1'b0;
    chk("store_cycles", 32'(vcnt), 32'd4);
    chk("store_done_valid", 32'(mem_wr_valid), 32'h0);
    chk("store_done_ready", 32'(cmd_ready), 32'h1);
    chk("store_cmd_held", 32'(acc2alu), 32'h1234);
    tick();
    cmd_valid = 1'b0; cmd = 3'd0;
    chk("store_cmd_taken", 32'(acc2alu), 32'h5555);

    // Reset in the middle of a store
    cmd_go(3'd3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_store_valid", 32'(mem_wr_valid), 32'h0);
    chk("rst_store_acc", 32'(acc2alu), 32'h0);

    // Overflowing writeback from positive ACC
    br_data = 16'h7FFF;
    cmd_go(3'd1);
    alu2acc = 16'h8000; alu_flags = 4'b0101;
    cmd_go(3'd2);
    tick();
`ifdef ACC_SAT_EN
    chk("ovf_acc", 32'(acc2alu), 32'h7FFF);
    chk("ovf_flags", 32'(flags), 32'h4);
`else
    chk("ovf_acc", 32'(acc2alu), 32'h8000);
    chk("ovf_flags", 32'(flags), 32'h5);
`endif

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      rst          = ($urandom_range(0, 63) == 0);
      cmd_valid    = ($urandom_range(0, 3) != 0);
      cmd          = 3'($urandom_range(0, 7));
      br_data      = pick();
      alu2acc      = pick();
      mr_data      = pick();
      alu_flags    = 4'($urandom_range(0, 15));
      mem_wr_ready = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
